// File: rtl/audio_in_i2s.sv
// -----------------------------------------------------------------------------
// audio_in_i2s
//   I2S receiver. Deserializes stereo PCM from an external ADC/codec into
//   parallel signed DATA_W-bit left/right samples. SCK, LRCK and SDIN are
//   asynchronous to clk and are oversampled (clk must be at least 4x SCK).
//
//   Optional build macro: AUDIO_IN_LJ_EN
//     defined   -> left-justified input: the MSB is taken on the same SCK rise
//                  that detects the word-select change (no one-bit delay).
//     undefined -> standard I2S with the one-bit delay after each LRCK edge.
//
//   Ports
//     clk        in   system clock (50 MHz)
//     rst        in   synchronous active-high reset
//     i2s_sck    in   bit clock from the external master (async)
//     i2s_lrck   in   word select (async), 0 = left, 1 = right
//     i2s_sdin   in   serial data (async)
//     snd_l      out  signed left sample, held until the next valid frame
//     snd_r      out  signed right sample, held until the next valid frame
//     snd_valid  out  one-clk pulse when snd_l/snd_r update
//     snd_lock   out  high after an error-free stereo frame, low after an error
//     frame_err  out  one-clk pulse when a slot closes short or overlong
// -----------------------------------------------------------------------------
module audio_in_i2s #(
  parameter int DATA_W   = 16,
  parameter int MAX_SLOT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i2s_sck,
  input  logic                     i2s_lrck,
  input  logic                     i2s_sdin,
  output logic signed [DATA_W-1:0] snd_l,
  output logic signed [DATA_W-1:0] snd_r,
  output logic                     snd_valid,
  output logic                     snd_lock,
  output logic                     frame_err
);

  // Counter must hold MAX_SLOT+1, the saturation value that marks an overlong slot.
  localparam int               CNT_W   = $clog2(MAX_SLOT + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_SLOT + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SLOT);

`ifdef AUDIO_IN_LJ_EN
  localparam bit LJ_MODE = 1'b1;
`else
  localparam bit LJ_MODE = 1'b0;
`endif

  typedef enum logic [1:0] {ST_HUNT, ST_DELAY, ST_SHIFT, ST_PAD} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sck_sync_q;
  logic [1:0]        lrck_sync_q;
  logic [1:0]        sdin_sync_q;
  logic              lrck_prev_q, lrck_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] snd_l_q, snd_l_d, snd_r_q, snd_r_d;
  logic              valid_q, valid_d, lock_q, lock_d, err_q, err_d;

  logic sck_rise, lrck_s, sdin_s, ws_chg, slot_bad;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign lrck_s   = lrck_sync_q[1];
  assign sdin_s   = sdin_sync_q[1];
  assign ws_chg   = sck_rise & (lrck_s ^ lrck_prev_q);
  // Saturate rather than wrap so a very long slot can never alias to a legal length.
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign slot_bad = (cnt_q < CNT_MIN) || (cnt_q > CNT_MAX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HUNT;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that leaves a variable unassigned infers a latch.
    state_d = state_q;
    if (sck_rise) begin
      if (ws_chg) begin
        state_d = LJ_MODE ? ST_SHIFT : ST_DELAY;
      end else begin
        case (state_q)
          ST_HUNT:  state_d = ST_HUNT;
          ST_DELAY: state_d = ST_SHIFT;
          ST_SHIFT: state_d = (cnt_inc == CNT_MIN) ? ST_PAD : ST_SHIFT;
          ST_PAD:   state_d = ST_PAD;
          default:  state_d = ST_HUNT;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    lrck_prev_d = sck_rise ? lrck_s : lrck_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    snd_l_d     = snd_l_q;
    snd_r_d     = snd_r_q;
    lock_d      = lock_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    if (ws_chg) begin
      // Close the slot that just ended; in HUNT there is no slot to close.
      if (state_q != ST_HUNT) begin
        if (slot_bad) begin
          err_d      = 1'b1;
          lock_d     = 1'b0;
          pend_vld_d = 1'b0;  // drops the frame up to the next left slot
        end else if (!lrck_s) begin
          // Right slot closed: emit only when a good left slot is waiting.
          if (pend_vld_q) begin
            snd_l_d = pend_q;
            snd_r_d = shift_q;
            valid_d = 1'b1;
            lock_d  = 1'b1;
          end
          pend_vld_d = 1'b0;
        end else begin
          pend_d     = shift_q;
          pend_vld_d = 1'b1;
        end
      end
      // Start the new slot. In LJ mode this rise already carries the MSB.
      if (LJ_MODE) begin
        shift_d = {{(DATA_W-1){1'b0}}, sdin_s};
        cnt_d   = CNT_W'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (sck_rise) begin
      if (state_q == ST_DELAY || state_q == ST_SHIFT) begin
        shift_d = {shift_q[DATA_W-2:0], sdin_s};
        cnt_d   = cnt_inc;
      end else if (state_q == ST_PAD) begin
        cnt_d = cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and input synchronizers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      snd_l_q     <= '0;
      snd_r_q     <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], i2s_sck};
      lrck_sync_q <= {lrck_sync_q[0], i2s_lrck};
      sdin_sync_q <= {sdin_sync_q[0], i2s_sdin};
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      snd_l_q     <= snd_l_d;
      snd_r_q     <= snd_r_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  assign snd_l     = snd_l_q;
  assign snd_r     = snd_r_q;
  assign snd_valid = valid_q;
  assign snd_lock  = lock_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_audio_in_i2s.sv
// -----------------------------------------------------------------------------
// tb_audio_in_i2s
//   Self-checking bench for audio_in_i2s. Streams are built as LRCK/data bit
//   lists, driven with a slow SCK, and the observed sample/error events are
//   compared with a reference model that decodes the same bit lists directly
//   from the slot rules (slot length, MSB-first word, left/right pairing).
//   Build with +define+AUDIO_IN_LJ_EN to exercise the left-justified variant.
// -----------------------------------------------------------------------------
module tb_audio_in_i2s;

  localparam int DW   = 16;
  localparam int MAXS = 32;
`ifdef AUDIO_IN_LJ_EN
  localparam int          OFF  = 0;  // data offset of the MSB inside a slot
  localparam logic [15:0] T6_L = 16'h0F0F;
  localparam logic [15:0] T6_R = 16'hF0F0;
`else
  localparam int          OFF  = 1;
  localparam logic [15:0] T6_L = 16'h1E1E;
  localparam logic [15:0] T6_R = 16'hE1E0;
`endif

  logic clk = 1'b0;
  logic rst, sck, lrck, sdin;
  logic signed [DW-1:0] snd_l, snd_r;
  logic snd_valid, snd_lock, frame_err;

  int cyc     = 0;
  int n_total = 0;
  int n_bad   = 0;
  int n_valid_got, n_err_got;

  typedef struct {
    bit          err;
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
    logic        lock;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  bit  mon_en = 1'b0;

  bit s_lr[$];   // LRCK per SCK period
  bit s_lj[$];   // left-justified data per SCK period
  bit s_d[$];    // data actually driven (s_lj delayed)
  int s_cyc[$];  // cycle count at which each SCK rise was driven

  audio_in_i2s #(.DATA_W(DW), .MAX_SLOT(MAXS)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_sck   (sck),
    .i2s_lrck  (lrck),
    .i2s_sdin  (sdin),
    .snd_l     (snd_l),
    .snd_r     (snd_r),
    .snd_valid (snd_valid),
    .snd_lock  (snd_lock),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (snd_valid) begin
        mon_e.err = 1'b0; mon_e.cyc = cyc; mon_e.l = snd_l; mon_e.r = snd_r;
        mon_e.lock = snd_lock;
        got_q.push_back(mon_e);
      end
      if (frame_err) begin
        mon_e.err = 1'b1; mon_e.cyc = cyc; mon_e.l = snd_l; mon_e.r = snd_r;
        mon_e.lock = snd_lock;
        got_q.push_back(mon_e);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sck = 1'b0; lrck = 1'b0; sdin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_stream();
    s_lr.delete(); s_lj.delete(); s_d.delete(); s_cyc.delete();
  endtask

  // One half-frame: word occupies the first wbits positions (left-justified).
  task automatic add_slot(input int len, input bit lr, input logic [31:0] word,
                          input int wbits, input bit pad_rand);
    for (int p = 0; p < len; p++) begin
      s_lr.push_back(lr);
      if (p < wbits) s_lj.push_back(word[wbits-1-p]);
      else           s_lj.push_back(pad_rand ? bit'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic add_frames(input int n, input int len, input logic [31:0] wl,
                            input logic [31:0] wr, input int wbits);
    for (int f = 0; f < n; f++) begin
      add_slot(len, 1'b0, wl, wbits, 1'b0);
      add_slot(len, 1'b1, wr, wbits, 1'b0);
    end
  endtask

  task automatic add_rand_frames(input int n);
    for (int f = 0; f < n; f++) begin
      add_slot(32, 1'b0, $urandom, DW, 1'b1);
      add_slot(32, 1'b1, $urandom, DW, 1'b1);
    end
  endtask

  // I2S puts the data one SCK later than the word-select edge.
  task automatic apply_delay(input int dly);
    s_d.delete();
    for (int i = 0; i < s_lj.size(); i++) begin
      if (i >= dly) s_d.push_back(s_lj[i-dly]);
      else          s_d.push_back(bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic drive(input int h, input int rst_idx);
    for (int i = 0; i < s_lr.size(); i++) begin
      if (i == rst_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.l",     {16'h0, snd_l}, 32'h0);
        check("mrst.r",     {16'h0, snd_r}, 32'h0);
        check("mrst.valid", 32'(snd_valid), 32'h0);
        check("mrst.lock",  32'(snd_lock),  32'h0);
        check("mrst.err",   32'(frame_err), 32'h0);
      end
      sck = 1'b0; lrck = s_lr[i]; sdin = s_d[i];
      repeat (h) @(negedge clk);
      sck = 1'b1;
      s_cyc.push_back(cyc);
      repeat (h) @(negedge clk);
    end
    sck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Reference decode of s_lr/s_d[lo:hi) from a freshly reset receiver.
  // Event time = SCK rise drive + 2 synchronizer clocks + 1 output register.
  task automatic model_seg(input int lo, input int hi);
    bit          prev, hunt, pv;
    int          st, len, cnt;
    logic [15:0] pend, v, last_l, last_r;
    ev_t         e;
    prev = 1'b0; hunt = 1'b1; pv = 1'b0; st = lo;
    pend = '0; last_l = '0; last_r = '0;
    for (int i = lo; i < hi; i++) begin
      if (s_lr[i] != prev) begin
        if (!hunt) begin
          len = i - st;
          cnt = len - OFF;
          v   = '0;
          for (int b = 0; b < DW; b++)
            if (st + OFF + b < i) v[DW-1-b] = s_d[st+OFF+b];
          e.cyc = s_cyc[i] + 3;
          if (cnt < DW || cnt > MAXS) begin
            e.err = 1'b1; e.l = last_l; e.r = last_r; e.lock = 1'b0;
            exp_q.push_back(e);
            pv = 1'b0;
          end else if (s_lr[st] == 1'b0) begin
            pend = v; pv = 1'b1;
          end else begin
            if (pv) begin
              e.err = 1'b0; e.l = pend; e.r = v; e.lock = 1'b1;
              exp_q.push_back(e);
              last_l = pend; last_r = v;
            end
            pv = 1'b0;
          end
        end
        st = i; hunt = 1'b0; prev = s_lr[i];
      end
    end
  endtask

  task automatic compare(input string name);
    int n;
    n_valid_got = 0; n_err_got = 0;
    foreach (got_q[i]) begin
      if (got_q[i].err) n_err_got++;
      else              n_valid_got++;
    end
    check({name, ".nev"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.ev%0d.err",  name, i), 32'(got_q[i].err),  32'(exp_q[i].err));
      check($sformatf("%s.ev%0d.cyc",  name, i), got_q[i].cyc,       exp_q[i].cyc);
      check($sformatf("%s.ev%0d.l",    name, i), {16'h0, got_q[i].l}, {16'h0, exp_q[i].l});
      check($sformatf("%s.ev%0d.r",    name, i), {16'h0, got_q[i].r}, {16'h0, exp_q[i].r});
      check($sformatf("%s.ev%0d.lock", name, i), 32'(got_q[i].lock), 32'(exp_q[i].lock));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_test(input string name, input int h, input int rst_idx);
    got_q.delete(); exp_q.delete(); s_cyc.delete();
    mon_en = 1'b1;
    drive(h, rst_idx);
    mon_en = 1'b0;
    if (rst_idx < 0) begin
      model_seg(0, s_lr.size());
    end else begin
      model_seg(0, rst_idx);
      model_seg(rst_idx, s_lr.size());
    end
    compare(name);
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return $urandom_range(4, DW - 1);
    else if (r == 1) return $urandom_range(MAXS + 2, MAXS + 16);
    else             return $urandom_range(DW + 1, MAXS + 1);
  endfunction

  initial begin
    rst = 1'b1; sck = 1'b0; lrck = 1'b0; sdin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.l",     {16'h0, snd_l}, 32'h0);
    check("rst.r",     {16'h0, snd_r}, 32'h0);
    check("rst.valid", 32'(snd_valid), 32'h0);
    check("rst.lock",  32'(snd_lock),  32'h0);
    check("rst.err",   32'(frame_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 64 SCK/frame, fixed words; the first (partial) frame is never output.
    do_reset(); clear_stream();
    add_frames(3, 32, 32'h8001, 32'h7FFE, DW);
    add_slot(32, 1'b0, 32'h8001, DW, 1'b0);
    apply_delay(OFF);
    run_test("t1", 2, -1);
    check("t1.nvalid", n_valid_got,      2);
    check("t1.l",      {16'h0, snd_l},   32'h8001);
    check("t1.r",      {16'h0, snd_r},   32'h7FFE);
    check("t1.lock",   32'(snd_lock),    32'h1);

    // 24-bit words in 24-bit slots: top 16 bits kept.
    do_reset(); clear_stream();
    add_frames(3, 24, 32'h123456, 32'hABCDEF, 24);
    add_slot(24, 1'b0, 32'h123456, 24, 1'b0);
    apply_delay(OFF);
    run_test("t2", 3, -1);
    check("t2.nerr", n_err_got,      0);
    check("t2.l",    {16'h0, snd_l}, 32'h1234);
    check("t2.r",    {16'h0, snd_r}, 32'hABCD);

    // Short left slot mid-stream, then recovery.
    do_reset(); clear_stream();
    add_rand_frames(2);
    add_slot(10, 1'b0, $urandom, DW, 1'b1);
    add_slot(32, 1'b1, $urandom, DW, 1'b1);
    add_rand_frames(2);
    add_slot(32, 1'b0, $urandom, DW, 1'b1);
    apply_delay(OFF);
    run_test("t3", 2, -1);
    check("t3.nerr", n_err_got,   1);
    check("t3.lock", 32'(snd_lock), 32'h1);

    // Overlong (40-bit) left slot: error at close, outputs held.
    do_reset(); clear_stream();
    add_rand_frames(2);
    add_slot(40, 1'b0, $urandom, DW, 1'b1);
    add_slot(32, 1'b1, $urandom, DW, 1'b1);
    add_rand_frames(2);
    add_slot(32, 1'b0, $urandom, DW, 1'b1);
    apply_delay(OFF);
    run_test("t4", 2, -1);
    check("t4.nerr", n_err_got, 1);

    // Reset pulse in the middle of a right slot.
    do_reset(); clear_stream();
    add_rand_frames(4);
    add_slot(32, 1'b0, $urandom, DW, 1'b1);
    apply_delay(OFF);
    run_test("t5", 3, 110);
    check("t5.nvalid", n_valid_got, 2);

    // Left-justified stream; decodes shifted by one bit in I2S builds.
    do_reset(); clear_stream();
    add_frames(3, 32, 32'h0F0F, 32'hF0F0, DW);
    add_slot(32, 1'b0, 32'h0F0F, DW, 1'b0);
    apply_delay(0);
    run_test("t6", 2, -1);
    check("t6.l", {16'h0, snd_l}, {16'h0, T6_L});
    check("t6.r", {16'h0, snd_r}, {16'h0, T6_R});

    // Slot-length boundaries: min legal, max legal, one short, one over.
    do_reset(); clear_stream();
    add_rand_frames(1);
    add_slot(DW + OFF,       1'b0, $urandom, DW, 1'b1);
    add_slot(MAXS + OFF,     1'b1, $urandom, DW, 1'b1);
    add_slot(MAXS + OFF + 1, 1'b0, $urandom, DW, 1'b1);
    add_slot(32,             1'b1, $urandom, DW, 1'b1);
    add_slot(32,             1'b0, $urandom, DW, 1'b1);
    add_slot(DW + OFF - 1,   1'b1, $urandom, DW, 1'b1);
    add_rand_frames(1);
    add_slot(32, 1'b0, $urandom, DW, 1'b1);
    apply_delay(OFF);
    run_test("t7", 2, -1);
    check("t7.nerr",   n_err_got,   2);
    check("t7.nvalid", n_valid_got, 2);

    // Randomized slot lengths, data and SCK ratio.
    for (int it = 0; it < 6; it++) begin
      do_reset(); clear_stream();
      for (int f = 0; f < 6; f++) begin
        add_slot(pick_len(), 1'b0, $urandom, DW, 1'b1);
        add_slot(pick_len(), 1'b1, $urandom, DW, 1'b1);
      end
      add_slot(32, 1'b0, $urandom, DW, 1'b1);
      apply_delay(OFF);
      run_test($sformatf("rnd%0d", it), $urandom_range(2, 4), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
